// File: rtl/seg_marquee_if.sv
// rtl/seg_marquee_if.sv - message write, scroll control and display bundle for seg_marquee
interface seg_marquee_if #(
  parameter int NUM_DIGITS = 8,
  parameter int ADDR_W     = 3
);
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [6:0]              wr_data;
  logic [ADDR_W:0]         msg_len;
  logic                    run;
  logic                    step;
  logic                    dir;
  logic [7*NUM_DIGITS-1:0] hex;
  logic [ADDR_W:0]         ptr;
  logic                    wrap;

  // Board-side logic that drives the message and scroll controls
  modport master (
    output wr_en, wr_addr, wr_data, msg_len, run, step, dir,
    input  hex, ptr, wrap
  );

  // The marquee engine itself
  modport slave (
    input  wr_en, wr_addr, wr_data, msg_len, run, step, dir,
    output hex, ptr, wrap
  );
endinterface

// File: rtl/seg_marquee.sv
// rtl/seg_marquee.sv - scrolling-text engine for a bank of active-low 7-segment digits
module seg_marquee #(
  parameter int NUM_DIGITS = 8,
  parameter int ADDR_W     = 3,
  parameter int GAP        = 3,
  parameter int TICK_DIV   = 50000000,
  parameter int DIV_W      = 26
) (
  input  logic         CLOCK_50,
  input  logic         Resetn,
  seg_marquee_if.slave bus
);

  localparam int               MSG_LEN  = 2**ADDR_W;
  // Stream indices reach MSG_LEN+GAP, which needs one bit more than ptr
  localparam int               EW       = ADDR_W + 2;
  localparam logic [6:0]       BLANK    = 7'h7F;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [ADDR_W:0]  LEN_MAX  = (ADDR_W+1)'(MSG_LEN);

  logic [DIV_W-1:0] div_q;
  logic [6:0]       mem [MSG_LEN];
  logic [6:0]       dig [NUM_DIGITS];
  logic [ADDR_W:0]  ptr_q;
  logic             wrap_q;

  logic             tick;
  logic             shift;
  logic [ADDR_W:0]  len_c;
  logic [EW-1:0]    end_w;
  logic             out_range;
  logic [EW-1:0]    idx;
  logic [EW-1:0]    idx_inc;
  logic [6:0]       ins_char;
  logic [ADDR_W:0]  ptr_nxt;
  logic             wrap_nxt;

  // Shift decision, stream index selection and character fetch
  always_comb begin
    tick      = bus.run && (div_q == DIV_LAST);
    shift     = tick || (!bus.run && bus.step);
    len_c     = (bus.msg_len > LEN_MAX) ? LEN_MAX : bus.msg_len;
    end_w     = EW'(len_c) + EW'(GAP);
    // A shrunken msg_len can leave ptr past the end; restart the pass then
    out_range = (EW'(ptr_q) >= end_w);
    idx       = out_range ? '0 : EW'(ptr_q);
    idx_inc   = idx + EW'(1);
    ins_char  = BLANK;
    if (idx < EW'(len_c)) begin
      ins_char = mem[idx[ADDR_W-1:0]];
    end
    ptr_nxt  = '0;
    wrap_nxt = 1'b0;
    // Empty stream: keep inserting blanks with ptr parked at 0
    if (end_w != '0) begin
      ptr_nxt  = (idx_inc == end_w) ? '0 : idx_inc[ADDR_W:0];
      wrap_nxt = (idx_inc == end_w) || out_range;
    end
  end

  // Scroll-rate divider, parked at 0 whenever auto-scroll is off
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn || !bus.run || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Message store; a shift in the same cycle already fetched the old entry
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        mem[i] <= BLANK;
      end
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Digit shift register plus stream pointer and wrap pulse
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig[k] <= BLANK;
      end
      ptr_q  <= '0;
      wrap_q <= 1'b0;
    end else if (shift) begin
      if (!bus.dir) begin
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
          dig[k] <= dig[k-1];
        end
        dig[0] <= ins_char;
      end else begin
        for (int k = 0; k < NUM_DIGITS - 1; k++) begin
          dig[k] <= dig[k+1];
        end
        dig[NUM_DIGITS-1] <= ins_char;
      end
      ptr_q  <= ptr_nxt;
      wrap_q <= wrap_nxt;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
    assign bus.hex[7*g +: 7] = dig[g];
  end

  assign bus.ptr  = ptr_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_seg_marquee.sv
// tb/tb_seg_marquee.sv - scoreboard bench for seg_marquee
module tb_seg_marquee;

  localparam int ND  = 8;
  localparam int AW  = 3;
  localparam int GAP = 3;
  localparam int TD  = 4;

  localparam logic [6:0] CH_H = 7'b1001000;
  localparam logic [6:0] CH_E = 7'b0110000;
  localparam logic [6:0] CH_L = 7'b1110001;
  localparam logic [6:0] CH_O = 7'b0000001;
  localparam logic [6:0] BLK  = 7'h7F;

  typedef struct {
    logic [7*ND-1:0] hex;
    logic [AW:0]     ptr;
    logic            wrap;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t       sb_q[$];
  logic [6:0] m_mem [8];
  logic [6:0] m_dig [ND];
  logic [6:0] msg [5];
  int         m_ptr;
  int         m_div;
  bit         m_wrap;

  seg_marquee_if #(.NUM_DIGITS(ND), .ADDR_W(AW)) mif ();

  seg_marquee #(
    .NUM_DIGITS(ND), .ADDR_W(AW), .GAP(GAP), .TICK_DIV(TD), .DIV_W(26)
  ) dut (
    .CLOCK_50(clk),
    .Resetn  (resetn),
    .bus     (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dg(input int k);
    return mif.hex[7*k +: 7];
  endfunction

  // Advance the reference model by one clock edge and queue its outputs
  task automatic model_edge();
    exp_t       e;
    int         l, e_end, idx;
    bit         tick, shift, forced;
    logic [6:0] ins;
    if (!resetn) begin
      foreach (m_mem[i]) m_mem[i] = BLK;
      foreach (m_dig[i]) m_dig[i] = BLK;
      m_ptr = 0; m_wrap = 0; m_div = 0;
    end else begin
      tick  = mif.run && (m_div == TD - 1);
      shift = tick || (!mif.run && mif.step);
      if (!mif.run || tick) m_div = 0;
      else m_div++;
      m_wrap = 0;
      if (shift) begin
        l     = (int'(mif.msg_len) > 8) ? 8 : int'(mif.msg_len);
        e_end = l + GAP;
        if (e_end == 0) begin
          ins = BLK; m_ptr = 0;
        end else begin
          forced = (m_ptr >= e_end);
          idx    = forced ? 0 : m_ptr;
          ins    = (idx < l) ? m_mem[idx] : BLK;
          m_ptr  = (idx + 1 == e_end) ? 0 : idx + 1;
          m_wrap = (m_ptr == 0) || forced;
        end
        if (!mif.dir) begin
          for (int k = ND - 1; k > 0; k--) m_dig[k] = m_dig[k-1];
          m_dig[0] = ins;
        end else begin
          for (int k = 0; k < ND - 1; k++) m_dig[k] = m_dig[k+1];
          m_dig[ND-1] = ins;
        end
      end
      if (mif.wr_en) m_mem[mif.wr_addr] = mif.wr_data;
    end
    for (int k = 0; k < ND; k++) e.hex[7*k +: 7] = m_dig[k];
    e.ptr  = (AW+1)'(m_ptr);
    e.wrap = m_wrap;
    sb_q.push_back(e);
  endtask

  task automatic step_cycle();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_hex", 64'(mif.hex), 64'(e.hex));
    chk("sb_ptr", 64'(mif.ptr), 64'(e.ptr));
    chk("sb_wrap", 64'(mif.wrap), 64'(e.wrap));
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step_cycle();
  endtask

  task automatic pulse_step();
    mif.step = 1'b1;
    step_cycle();
    mif.step = 1'b0;
  endtask

  task automatic write_msg();
    mif.run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mif.wr_en   = 1'b1;
      mif.wr_addr = AW'(i);
      mif.wr_data = msg[i];
      step_cycle();
    end
    mif.wr_en = 1'b0;
  endtask

  initial begin
    msg[0] = CH_H; msg[1] = CH_E; msg[2] = CH_L; msg[3] = CH_L; msg[4] = CH_O;
    resetn      = 1'b0;
    mif.wr_en   = 1'b0;
    mif.wr_addr = '0;
    mif.wr_data = '0;
    mif.msg_len = 4'd5;
    mif.run     = 1'b0;
    mif.step    = 1'b0;
    mif.dir     = 1'b0;
    run_cycles(2);
    chk("rst_hex", 64'(mif.hex), {8'h00, {ND{BLK}}});
    chk("rst_ptr", 64'(mif.ptr), 64'd0);
    chk("rst_wrap", 64'(mif.wrap), 64'd0);
    resetn = 1'b1;

    // HELLO scrolling left
    write_msg();
    mif.run = 1'b1;
    run_cycles(20);
    chk("l5_d0", 64'(dg(0)), 64'(CH_O));
    chk("l5_d1", 64'(dg(1)), 64'(CH_L));
    chk("l5_d3", 64'(dg(3)), 64'(CH_E));
    chk("l5_d4", 64'(dg(4)), 64'(CH_H));
    chk("l5_d5", 64'(dg(5)), 64'(BLK));
    chk("l5_d7", 64'(dg(7)), 64'(BLK));
    chk("l5_ptr", 64'(mif.ptr), 64'd5);
    run_cycles(12);
    chk("l8_wrap", 64'(mif.wrap), 64'd1);
    chk("l8_ptr", 64'(mif.ptr), 64'd0);
    run_cycles(1);
    chk("l8_wrap_off", 64'(mif.wrap), 64'd0);
    run_cycles(19);
    chk("l13_d0", 64'(dg(0)), 64'(CH_O));
    chk("l13_d4", 64'(dg(4)), 64'(CH_H));
    chk("l13_d5", 64'(dg(5)), 64'(BLK));
    chk("l13_d6", 64'(dg(6)), 64'(BLK));
    chk("l13_d7", 64'(dg(7)), 64'(BLK));

    // Reset in the middle of scrolling, then divider restart timing
    run_cycles(6);
    resetn = 1'b0;
    run_cycles(1);
    chk("mrst_hex", 64'(mif.hex), {8'h00, {ND{BLK}}});
    chk("mrst_ptr", 64'(mif.ptr), 64'd0);
    chk("mrst_wrap", 64'(mif.wrap), 64'd0);
    resetn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      run_cycles(1);
      chk("restart_ptr", 64'(mif.ptr), (i == 4) ? 64'd1 : 64'd0);
    end

    // HELLO scrolling right
    resetn  = 1'b0;
    mif.run = 1'b0;
    run_cycles(1);
    resetn = 1'b1;
    write_msg();
    mif.dir = 1'b1;
    mif.run = 1'b1;
    run_cycles(20);
    chk("r5_d7", 64'(dg(7)), 64'(CH_O));
    chk("r5_d4", 64'(dg(4)), 64'(CH_E));
    chk("r5_d3", 64'(dg(3)), 64'(CH_H));
    chk("r5_d0", 64'(dg(0)), 64'(BLK));
    chk("r5_d2", 64'(dg(2)), 64'(BLK));
    chk("r5_ptr", 64'(mif.ptr), 64'd5);

    // Manual stepping, then step ignored while running
    mif.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_step();
      run_cycles(9);
    end
    chk("step3_ptr", 64'(mif.ptr), 64'd0);
    mif.run  = 1'b1;
    mif.step = 1'b1;
    run_cycles(8);
    mif.step = 1'b0;
    mif.run  = 1'b0;
    chk("run_step_ptr", 64'(mif.ptr), 64'd2);

    // Shrink msg_len below ptr
    repeat (4) pulse_step();
    chk("pre_shrink_ptr", 64'(mif.ptr), 64'd6);
    mif.msg_len = 4'd2;
    pulse_step();
    chk("shrink_char", 64'(dg(7)), 64'(CH_H));
    chk("shrink_ptr", 64'(mif.ptr), 64'd1);
    chk("shrink_wrap", 64'(mif.wrap), 64'd1);

    // Oversized msg_len clamps to 8 entries
    mif.msg_len = 4'd9;
    repeat (9) pulse_step();
    chk("clamp_ptr10", 64'(mif.ptr), 64'd10);
    pulse_step();
    chk("clamp_ptr0", 64'(mif.ptr), 64'd0);
    chk("clamp_wrap", 64'(mif.wrap), 64'd1);

    // Write colliding with the fetch of the same entry
    mif.dir     = 1'b0;
    mif.msg_len = 4'd5;
    mif.step    = 1'b1;
    mif.wr_en   = 1'b1;
    mif.wr_addr = '0;
    mif.wr_data = 7'h12;
    step_cycle();
    mif.step  = 1'b0;
    mif.wr_en = 1'b0;
    chk("coll_old", 64'(dg(0)), 64'(CH_H));
    repeat (7) pulse_step();
    chk("coll_ptr", 64'(mif.ptr), 64'd0);
    pulse_step();
    chk("coll_new", 64'(dg(0)), 64'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
